// File: rtl/sram_data_responder.sv
// Data-memory responder: one outstanding request, optional wait states, then a
// byte-masked write or full-word read of an internal word RAM and a one-cycle response.
`timescale 1ns/1ps
module sram_data_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        addr_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t              state_r;
  logic [CNT_W-1:0]    count_r;
  logic [ADDR_W-1:0]   wordAddr_r;
  logic                wr_r;
  logic [3:0]          wstrb_r;
  logic [31:0]         wdata_r;
  logic                outOfRange_r;
  logic                ramWrite_s;
  logic                ramRead_s;

  logic [31:0] mem [2**ADDR_W];

  // Any set bit above the word-address field is an access outside the RAM.
  function automatic logic isOutOfRange(input logic [31:0] byteAddr);
    return (byteAddr >> (ADDR_W + 2)) != 32'd0;
  endfunction

  // Handshake readiness depends on state only; RAM strobes qualify the ACCESS cycle.
  always_comb begin
    addr_ok    = (state_r == IDLE);
    ramWrite_s = (state_r == ACCESS) && wr_r && !outOfRange_r;
    ramRead_s  = (state_r == ACCESS) && !wr_r && !outOfRange_r;
  end

  // Byte-lane write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (ramWrite_s) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_r[i]) begin
          mem[wordAddr_r][8*i +: 8] <= wdata_r[8*i +: 8];
        end
      end
    end
  end

  // Request sequencer with registered response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      count_r      <= {CNT_W{1'b0}};
      wordAddr_r   <= {ADDR_W{1'b0}};
      wr_r         <= 1'b0;
      wstrb_r      <= 4'b0000;
      wdata_r      <= 32'd0;
      outOfRange_r <= 1'b0;
      data_ok      <= 1'b0;
      rdata        <= 32'd0;
      addr_err     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          data_ok <= 1'b0;
          if (req) begin
            wordAddr_r   <= addr[ADDR_W+1:2];
            wr_r         <= wr;
            wstrb_r      <= wstrb;
            wdata_r      <= wdata;
            outOfRange_r <= isOutOfRange(addr);
            if (WAIT_CYCLES == 0) begin
              state_r <= ACCESS;
            end else begin
              state_r <= WAIT;
              count_r <= CNT_W'(WAIT_CYCLES);
            end
          end
        end
        WAIT: begin
          count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
          if (count_r <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
            state_r <= ACCESS;
          end
        end
        ACCESS: begin
          // The synchronous RAM read lands directly in the output register.
          state_r  <= RESP;
          data_ok  <= 1'b1;
          addr_err <= outOfRange_r;
          rdata    <= ramRead_s ? mem[wordAddr_r] : 32'd0;
        end
        RESP: begin
          state_r <= IDLE;
          data_ok <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          data_ok <= 1'b0;
        end
      endcase
    end
  end

endmodule
